// File: rtl/data_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_resp_pkg
// Purpose : Shared constants and types for the data-memory responder: data
//           width, MMIO register offsets, MMIO window size and the read-data
//           source selector used by the top-level output mux.
// Macros  : none (DMEM_MMIO_EN is consumed by data_mem_resp)
// Revision: 1.0 - initial release
// ============================================================================
package data_mem_resp_pkg;

  localparam int unsigned XLEN = 32;

  // Byte offsets of the MMIO registers relative to MMIO_BASE.
  localparam logic [7:0] DMEM_CYC_LO = 8'h00;
  localparam logic [7:0] DMEM_CYC_HI = 8'h04;
  localparam logic [7:0] DMEM_TOHOST = 8'h08;

  // Size of the decoded MMIO window in bytes.
  localparam logic [XLEN-1:0] MMIO_WIN_BYTES = 32'd256;

  // Where the registered read data comes from on a read.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

endpackage : data_mem_resp_pkg
`default_nettype wire

// File: rtl/data_mem_resp_mmio_regs.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mmio_regs
// Purpose : MMIO register block: free-running 64-bit cycle counter (RO, two
//           words) and a tohost register (RW) with a sticky done flag.
//           Provides a combinational read mux; the caller registers it.
// Ports   : clk, rst       - clock / async active-high reset
//           sel_i          - access targets the MMIO window this cycle
//           we_i           - 1 = write
//           reg_i          - word index inside the window (offset[7:2])
//           wdata_i        - write data
//           rdata_o        - read mux output (current register value)
//           hit_o          - reg_i decodes to an implemented register
//           done_o         - sticky: tohost has been written
//           tohost_o       - last value written to tohost
// Revision: 1.0 - initial release
// ============================================================================
module dmem_mmio_regs
  import data_mem_resp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_i,
  input  logic            we_i,
  input  logic [5:0]      reg_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            hit_o,
  output logic            done_o,
  output logic [XLEN-1:0] tohost_o
);

  localparam logic [5:0] REG_CYC_LO = DMEM_CYC_LO[7:2];
  localparam logic [5:0] REG_CYC_HI = DMEM_CYC_HI[7:2];
  localparam logic [5:0] REG_TOHOST = DMEM_TOHOST[7:2];

  logic [63:0]     cnt_q,    cnt_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic            done_q,   done_d;

  always_comb begin
    // Wraps naturally from all-ones to zero.
    cnt_d    = cnt_q + 64'd1;
    tohost_d = tohost_q;
    done_d   = done_q;
    rdata_o  = '0;
    hit_o    = 1'b1;
    case (reg_i)
      REG_CYC_LO: rdata_o = cnt_q[31:0];
      REG_CYC_HI: rdata_o = cnt_q[63:32];
      REG_TOHOST: rdata_o = tohost_q;
      default:    hit_o   = 1'b0;
    endcase
    // Writes to the counter words are silently ignored.
    if (sel_i && we_i && (reg_i == REG_TOHOST)) begin
      tohost_d = wdata_i;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      tohost_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tohost_q <= tohost_d;
      done_q   <= done_d;
    end
  end

  assign done_o   = done_q;
  assign tohost_o = tohost_q;

endmodule : dmem_mmio_regs
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_resp
// Purpose : Data-memory responder for the core's data port. Word-addressed
//           single-port RAM with one-cycle registered read data, sticky
//           misalignment / out-of-range flags and an optional MMIO window
//           (cycle counter + tohost), enabled by defining DMEM_MMIO_EN.
// Ports   : clk, rst       - clock / async active-high reset
//           ce_i, we_i     - access enable, 1 = write
//           addr_i         - byte address
//           wdata_i        - write data
//           rdata_o        - registered read data, holds between reads
//           misalign_o     - sticky: an access had addr_i[1:0] != 0
//           oob_o          - sticky: an access hit neither RAM nor MMIO
//           done_o         - sticky: tohost written (0 without MMIO)
//           tohost_o       - last tohost value (0 without MMIO)
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned     DEPTH     = 1024,
  parameter                  INIT_FILE = "",
  parameter logic [XLEN-1:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            oob_o,
  output logic            done_o,
  output logic [XLEN-1:0] tohost_o
);

  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH * 4);

  logic [XLEN-1:0] mem_q [DEPTH];

  logic [AW-1:0]   w_word;
  logic            w_in_ram;
  logic            w_in_win;
  logic            w_mmio_hit;
  logic [XLEN-1:0] w_mmio_rdata;
  rd_src_e         w_src;

  logic [XLEN-1:0] rdata_q,    rdata_d;
  logic            misalign_q, misalign_d;
  logic            oob_q,      oob_d;

  assign w_word   = addr_i[AW+1:2];
  assign w_in_ram = (addr_i < RAM_BYTES);

`ifdef DMEM_MMIO_EN
  logic [XLEN-1:0] w_win_off;

  // Unsigned offset: addresses below MMIO_BASE wrap high and fail the compare.
  assign w_win_off = addr_i - MMIO_BASE;
  assign w_in_win  = (w_win_off < MMIO_WIN_BYTES);

  dmem_mmio_regs u_mmio (
    .clk      (clk),
    .rst      (rst),
    .sel_i    (ce_i && w_in_win && !w_in_ram),
    .we_i     (we_i),
    .reg_i    (w_win_off[7:2]),
    .wdata_i  (wdata_i),
    .rdata_o  (w_mmio_rdata),
    .hit_o    (w_mmio_hit),
    .done_o   (done_o),
    .tohost_o (tohost_o)
  );
`else
  assign w_in_win     = 1'b0;
  assign w_mmio_hit   = 1'b0;
  assign w_mmio_rdata = '0;
  assign done_o       = 1'b0;
  assign tohost_o     = '0;
`endif

  // RAM takes priority should the window ever overlap it.
  always_comb begin
    w_src = SRC_ZERO;
    if (w_in_ram)                     w_src = SRC_RAM;
    else if (w_in_win && w_mmio_hit)  w_src = SRC_MMIO;
  end

  always_comb begin
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    oob_d      = oob_q;
    if (ce_i) begin
      if (addr_i[1:0] != 2'b00) misalign_d = 1'b1;
      if (w_src == SRC_ZERO)    oob_d      = 1'b1;
      if (!we_i) begin
        case (w_src)
          SRC_RAM:  rdata_d = mem_q[w_word];
          SRC_MMIO: rdata_d = w_mmio_rdata;
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  // RAM contents are never reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ce_i && we_i && w_in_ram && !rst) mem_q[w_word] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      oob_q      <= oob_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;
  assign oob_o      = oob_q;

endmodule : data_mem_resp
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_resp
// Purpose : Self-checking bench for data_mem_resp. Reads push the expected
//           data into a queue; a monitor pops and compares one cycle after
//           each read edge. Flag outputs are compared directly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        misalign_o, oob_o, done_o;
  logic [31:0] tohost_o;

  int n_vec = 0;
  int n_err = 0;

  // mask == 0 means "capture only": value is stored in cap_q for a later check.
  typedef struct { logic [31:0] exp; logic [31:0] mask; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] cap_q[$];
  logic        rd_pend;

  data_mem_resp #(
    .DEPTH     (DEPTH),
    .INIT_FILE (""),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .oob_o      (oob_o),
    .done_o     (done_o),
    .tohost_o   (tohost_o)
  );

  always #5 clk = ~clk;

  // A read accepted at a rising edge produces data checked at the next falling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= ce_i & ~we_i;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_underflow: read data %h with no expected entry", rdata_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.mask == 32'h0) begin
          cap_q.push_back(rdata_o);
        end else begin
          n_vec++;
          if ((rdata_o & e.mask) !== (e.exp & e.mask)) begin
            n_err++;
            $display("FAIL rdata: got %h expected %h", rdata_o, e.exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] mask);
    exp_t e;
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    e.exp = exp; e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce_i = 1'b0; we_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_rdata",    rdata_o,    32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    chk("rst_oob",      {31'h0, oob_o},      32'h0);
    chk("rst_done",     {31'h0, done_o},     32'h0);
    chk("rst_tohost",   tohost_o,   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: write then read same word next cycle
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, '1);

    // 2: preload 1,2,3 then back-to-back reads; data must hold while idle
    wr(32'h0, 32'd1);
    wr(32'h4, 32'd2);
    wr(32'h8, 32'd3);
    rd(32'h0, 32'd1, '1);
    rd(32'h4, 32'd2, '1);
    rd(32'h8, 32'd3, '1);
    idle(3);
    chk("hold_rdata", rdata_o, 32'd3);
    chk("no_misalign_yet", {31'h0, misalign_o}, 32'h0);

    // 3: misaligned read uses aligned word; flag is sticky
    rd(32'h13, 32'hDEAD_BEEF, '1);
    idle(1);
    chk("misalign_set", {31'h0, misalign_o}, 32'h1);
    chk("oob_clear",    {31'h0, oob_o},      32'h0);
    rd(32'h4, 32'd2, '1);
    idle(1);
    chk("misalign_sticky", {31'h0, misalign_o}, 32'h1);

    // 4: out-of-range read returns 0; out-of-range write is dropped
    rd(DEPTH * 4, 32'h0, '1);
    idle(1);
    chk("oob_set", {31'h0, oob_o}, 32'h1);
    wr(DEPTH * 4, 32'h5555_AAAA);
    rd(32'h0, 32'd1, '1);

    // 5: async reset clears outputs mid-cycle; RAM survives
    rd(32'h10, 32'hDEAD_BEEF, '1);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rdata",    rdata_o, 32'h0);
    chk("async_misalign", {31'h0, misalign_o}, 32'h0);
    chk("async_oob",      {31'h0, oob_o},      32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h10, 32'hDEAD_BEEF, '1);
    rd(32'h8, 32'd3, '1);
    idle(1);

`ifdef DMEM_MMIO_EN
    // 6: counter delta over 5 cycles, tohost write, RO write ignored, hole offset
    rd(MMIO_BASE, 32'h0, 32'h0);
    idle(4);
    rd(MMIO_BASE, 32'h0, 32'h0);
    idle(2);
    if (cap_q.size() == 2) chk("cyc_delta", cap_q[1] - cap_q[0], 32'd5);
    else chk("cyc_captures", cap_q.size(), 32'd2);
    rd(MMIO_BASE + 32'h4, 32'h0, '1);
    wr(MMIO_BASE, 32'h1234_5678);
    wr(MMIO_BASE + 32'h8, 32'h1);
    idle(1);
    chk("done_set",   {31'h0, done_o}, 32'h1);
    chk("tohost_val", tohost_o,        32'h1);
    chk("mmio_no_oob", {31'h0, oob_o}, 32'h0);
    rd(MMIO_BASE + 32'h8, 32'h1, '1);
    rd(MMIO_BASE + 32'hC, 32'h0, '1);
    idle(1);
    chk("hole_oob", {31'h0, oob_o}, 32'h1);
`else
    // 6: without MMIO the tohost address is plain out-of-range
    chk("pre_oob", {31'h0, oob_o}, 32'h0);
    wr(MMIO_BASE + 32'h8, 32'h1);
    idle(1);
    chk("nommio_oob",    {31'h0, oob_o},  32'h1);
    chk("nommio_done",   {31'h0, done_o}, 32'h0);
    chk("nommio_tohost", tohost_o,        32'h0);
    rd(MMIO_BASE, 32'h0, '1);
`endif

    // Drain the scoreboard with a bounded wait.
    idle(2);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_data_mem_resp
`default_nettype wire
